// File: rtl/uni_arbiter_pkg.sv
// Shared types for the uni request fabric: bus widths, request kinds and
// the two-port arbiter state encoding.
package uni_arbiter_pkg;

    localparam int UNI_ADDR_WIDTH = 32;
    localparam int UNI_DATA_WIDTH = 128;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_typ_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT_I,
        ARB_GNT_D
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_e;

    // Request-side fields carried through the arbiter unmodified.
    typedef struct packed {
        req_typ_e                    reqtyp;
        logic [UNI_ADDR_WIDTH-1:0]   addr;
        logic [UNI_DATA_WIDTH-1:0]   wdata;
        logic [1:0]                  size;
        logic                        cachable;
    } uni_req_t;

    function automatic arb_state_e grant_state(input arb_port_e port);
        return (port == PORT_D) ? ARB_GNT_D : ARB_GNT_I;
    endfunction

endpackage

// File: rtl/uni_arbiter_if.sv
// uni request interface: one outstanding transaction, valid held until a
// single-cycle ready, read data qualified by that ready.
interface uni_if;
    import uni_arbiter_pkg::*;

    logic                        valid;
    logic                        ready;
    req_typ_e                    reqtyp;
    logic [UNI_ADDR_WIDTH-1:0]   addr;
    logic [UNI_DATA_WIDTH-1:0]   wdata;
    logic [1:0]                  size;
    logic                        cachable;
    logic [UNI_DATA_WIDTH-1:0]   rdata;

    modport Master (
        output valid, reqtyp, addr, wdata, size, cachable,
        input  ready, rdata
    );

    modport Slave (
        input  valid, reqtyp, addr, wdata, size, cachable,
        output ready, rdata
    );

endinterface

// File: rtl/uni_arbiter.sv
// Round-robin 2:1 arbiter merging the I-cache and D-cache uni ports onto the
// single uni master feeding the AXI bridge; each grant spans a whole transaction.
module uni_arbiter
    import uni_arbiter_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    uni_if.Slave  UniIf_I,
    uni_if.Slave  UniIf_D,
    uni_if.Master UniIf_M
);

    arb_state_e state_q, state_d;
    arb_port_e  last_gnt_q, last_gnt_d;
    logic       sel_d_q, sel_d_d;

    arb_port_e  winner;
    logic       any_req;

    uni_req_t   req_i, req_d, req_m;

    // Tie goes to the port that did not win last time.
    always_comb begin : arbitrate
        any_req = UniIf_I.valid | UniIf_D.valid;
        if (UniIf_I.valid && UniIf_D.valid) begin
            winner = (last_gnt_q == PORT_I) ? PORT_D : PORT_I;
        end else if (UniIf_D.valid) begin
            winner = PORT_D;
        end else begin
            winner = PORT_I;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which is what keeps latches from being inferred.
    always_comb begin : next_state
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d    = grant_state(winner);
                    last_gnt_d = winner;
                end
            end
            ARB_GNT_I, ARB_GNT_D: begin
                if (UniIf_M.ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        // Idle also parks the mux on D, so only GNT_I selects the I port.
        sel_d_d = (state_d != ARB_GNT_I);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin : state_regs
        if (!i_rst_n) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= PORT_I;
            sel_d_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            sel_d_q    <= sel_d_d;
        end
    end

    assign req_i = {UniIf_I.reqtyp, UniIf_I.addr, UniIf_I.wdata, UniIf_I.size, UniIf_I.cachable};
    assign req_d = {UniIf_D.reqtyp, UniIf_D.addr, UniIf_D.wdata, UniIf_D.size, UniIf_D.cachable};
    assign req_m = sel_d_q ? req_d : req_i;

    assign UniIf_M.reqtyp   = req_m.reqtyp;
    assign UniIf_M.addr     = req_m.addr;
    assign UniIf_M.wdata    = req_m.wdata;
    assign UniIf_M.size     = req_m.size;
    assign UniIf_M.cachable = req_m.cachable;

    // Valid depends only on registered state and requester valids, never on M.ready.
    assign UniIf_M.valid = ((state_q == ARB_GNT_I) & UniIf_I.valid)
                         | ((state_q == ARB_GNT_D) & UniIf_D.valid);

    assign UniIf_I.ready = UniIf_M.ready & (state_q == ARB_GNT_I);
    assign UniIf_D.ready = UniIf_M.ready & (state_q == ARB_GNT_D);

    assign UniIf_I.rdata = UniIf_M.rdata;
    assign UniIf_D.rdata = UniIf_M.rdata;

endmodule
